cla15_accumulator: RTL and testbench

CLA15_ACCUMULATOR -- requirements
Module: cla15_accumulator

---
 rtl/cla15_accumulator.sv | 127 ++++++++++++
 tb/tb_cla15_accumulator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla15_accumulator.sv
// cla15_accumulator: 15-bit accumulator driving an external CLA add/sub.
// Optional saturation on overflow under macro CLA15_ACC_SAT_EN.
module cla15_accumulator (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_data,
  input  logic        in_mode,
  input  logic        in_clear,
  output logic [14:0] add_a,
  output logic [14:0] add_b,
  output logic        add_mode,
  input  logic [14:0] add_s,
  input  logic        add_cout,
  input  logic        add_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_acc,
  output logic        out_cout,
  output logic        out_ovf,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [14:0] acc;
  logic [14:0] b_reg;
  logic        mode_reg;
  logic        cout_r;
  logic        ovf_r;
  logic [7:0]  cnt;
  logic [14:0] acc_ld;
  logic        accept;
  logic        do_clr;
  logic        do_exec;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign accept    = in_ready & in_valid;
  assign do_clr    = accept & in_clear;
  assign do_exec   = (state == EXEC);

  assign add_a    = acc;
  assign add_b    = b_reg;
  assign add_mode = mode_reg;

  assign out_acc  = acc;
  assign out_cout = cout_r;
  assign out_ovf  = ovf_r;
  assign op_count = cnt;

  // Next-state logic: clear skips EXEC, RESP waits for out_ready.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = in_clear ? RESP : EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Value loaded into the accumulator at the end of EXEC.
  always_comb begin
    acc_ld = add_s;
`ifdef CLA15_ACC_SAT_EN
    if (add_ovf) begin
      acc_ld = acc[14] ? 15'h4000 : 15'h3FFF;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture and accumulator/status updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      b_reg    <= '0;
      mode_reg <= 1'b0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        b_reg    <= in_data;
        mode_reg <= in_mode;
      end
      if (do_clr) begin
        acc    <= in_data;
        cout_r <= 1'b0;
        ovf_r  <= 1'b0;
        cnt    <= '0;
      end else if (do_exec) begin
        acc    <= acc_ld;
        cout_r <= add_cout;
        ovf_r  <= ovf_r | add_ovf;
        if (cnt != 8'hFF) begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla15_accumulator.sv
// tb_cla15_accumulator: random operations checked against an integer
// model of the accumulator; the external CLA adder is modelled here.
module tb_cla15_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_data;
  logic        in_mode;
  logic        in_clear;
  logic [14:0] add_a;
  logic [14:0] add_b;
  logic        add_mode;
  logic [14:0] add_s;
  logic        add_cout;
  logic        add_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_acc;
  logic        out_cout;
  logic        out_ovf;
  logic [7:0]  op_count;

  int n_chk = 0;
  int n_err = 0;

  int m_acc;
  bit m_cout;
  bit m_ovf;
  int m_cnt;

  always #5 clk = ~clk;

  cla15_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_clear  (in_clear),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_mode  (add_mode),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .add_ovf   (add_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .op_count  (op_count)
  );

  // External 15-bit add/sub: subtract as a + ~b + 1.
  always_comb begin
    logic [15:0] t;
    if (add_mode) t = {1'b0, add_a} + {1'b0, ~add_b} + 16'd1;
    else          t = {1'b0, add_a} + {1'b0, add_b};
    add_s    = t[14:0];
    add_cout = t[15];
    add_ovf  = (add_a[14] == (add_b[14] ^ add_mode))
             && (t[14] != add_a[14]);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] acc_bits();
    int v;
    v = m_acc;
    return v[14:0];
  endfunction

  task automatic model_reset();
    m_acc  = 0;
    m_cout = 0;
    m_ovf  = 0;
    m_cnt  = 0;
  endtask

  // Integer-level model of one operation.
  task automatic model_op(input bit clr, input bit md,
                          input logic [14:0] d);
    int a, b, r, ua, ub;
    logic [14:0] w;
    bit ov;
    if (clr) begin
      m_acc  = $signed(d);
      m_cout = 0;
      m_ovf  = 0;
      m_cnt  = 0;
    end else begin
      a  = m_acc;
      b  = $signed(d);
      r  = md ? a - b : a + b;
      ua = a & 32'h7FFF;
      ub = int'(d);
      m_cout = md ? (ua >= ub) : (ua + ub > 32767);
      ov = (r > 16383) || (r < -16384);
      m_ovf = m_ovf | ov;
      if (m_cnt < 255) m_cnt++;
`ifdef CLA15_ACC_SAT_EN
      if (r > 16383)       m_acc = 16383;
      else if (r < -16384) m_acc = -16384;
      else                 m_acc = r;
`else
      w = r[14:0];
      m_acc = $signed(w);
`endif
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_acc"},  out_acc,  acc_bits());
    chk({tag, "_cout"}, out_cout, m_cout);
    chk({tag, "_ovf"},  out_ovf,  m_ovf);
    chk({tag, "_cnt"},  op_count, m_cnt);
  endtask

  // One transaction; garbage is driven on ignored inputs meanwhile.
  task automatic do_op(input bit clr, input bit md,
                       input logic [14:0] d, input int hold,
                       input bit full);
    int t;
    logic [14:0] prev;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready", in_ready, 1);
    prev     = acc_bits();
    in_valid = 1'b1;
    in_clear = clr;
    in_mode  = md;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'($urandom);
    in_clear = 1'($urandom);
    in_mode  = 1'($urandom);
    in_data  = 15'($urandom);
    model_op(clr, md, d);
    if (!clr) begin
      out_ready = 1'($urandom);
      if (full) begin
        chk("exec_valid", out_valid, 0);
        chk("exec_rdy", in_ready, 0);
        chk("exec_a", add_a, prev);
        chk("exec_b", add_b, d);
        chk("exec_md", add_mode, md);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("resp_valid", out_valid, 1);
    if (full) begin
      chk("resp_rdy", in_ready, 0);
      chk_out("resp");
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_rdy", in_ready, 0);
      chk("hold_acc", out_acc, acc_bits());
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("rel_rdy", in_ready, 1);
    chk("rel_valid", out_valid, 0);
    if (full) chk("rel_acc", out_acc, acc_bits());
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_clear  = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdy", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_a", add_a, 0);
    chk("rst_b", add_b, 0);
    chk("rst_md", add_mode, 0);
    chk_out("rst");

    do_op(1, 0, 15'd4, 0, 1);
    do_op(0, 0, 15'd2, 0, 1);
    chk("r16_acc", out_acc, 6);
    chk("r16_cnt", op_count, 1);

    do_op(1, 0, 15'd8192, 0, 1);
    do_op(0, 0, 15'd8192, 1, 1);
`ifdef CLA15_ACC_SAT_EN
    chk("r17_acc", out_acc, 15'h3FFF);
`else
    chk("r17_acc", out_acc, 15'h4000);
`endif
    chk("r17_ovf", out_ovf, 1);
    do_op(0, 0, 15'd0, 0, 1);
    chk("r17_ovf2", out_ovf, 1);

    do_op(1, 0, 15'h4000, 0, 1);
    do_op(0, 1, 15'd16383, 0, 1);
    chk("r18_cout", out_cout, 1);
    chk("r18_ovf", out_ovf, 1);
`ifdef CLA15_ACC_SAT_EN
    chk("r18_acc", out_acc, 15'h4000);
`else
    chk("r18_acc", out_acc, 15'h0001);
`endif

    do_op(0, 0, 15'd7, 3, 1);

    // Reset during EXEC discards the operation.
    in_valid = 1'b1;
    in_clear = 1'b0;
    in_mode  = 1'b0;
    in_data  = 15'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rx_valid", out_valid, 0);
    chk("rx_rdy", in_ready, 1);
    chk("rx_b", add_b, 0);
    chk_out("rx");
    @(posedge clk); #1;
    chk("rx_valid2", out_valid, 0);

    do_op(1, 0, 15'd0, 0, 1);
    for (int i = 0; i < 260; i++) do_op(0, 0, 15'd1, 0, 0);
    chk("sat_cnt", op_count, 255);
    chk("sat_acc", out_acc, 15'd260);
    chk_out("sat");

    for (int i = 0; i < 300; i++) begin
      do_op(($urandom % 10) == 0, 1'($urandom), 15'($urandom),
            $urandom % 3, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
